// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared encodings for the memory stage
package memory_stage_pkg;

    // Writeback result source select
    localparam logic [1:0] RS_ALU  = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC4  = 2'b10;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Access size lives in funct3[1:0] for both loads and stores
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/memory_stage_load_align.sv
// rtl/memory_stage_load_align.sv - load lane select and sign/zero extension
module load_align
    import memory_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword out of the word and extend it
    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline MEM stage with data memory handshake and MEM/WB register
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_m_i,
    input  logic               reg_write_m_i,
    input  logic [1:0]         result_src_m_i,
    input  logic               mem_write_m_i,
    input  logic [2:0]         funct3_m_i,
    input  logic [D_WIDTH-1:0] alu_result_m_i,
    input  logic [D_WIDTH-1:0] write_data_m_i,
    input  logic [4:0]         rd_m_i,
    input  logic [D_WIDTH-1:0] pc_plus4_m_i,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [D_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]         dmem_be_o,
    output logic [D_WIDTH-1:0] dmem_wdata_o,
    input  logic               dmem_ack_i,
    input  logic [D_WIDTH-1:0] dmem_rdata_i,
    output logic               reg_write_w_o,
    output logic [1:0]         result_src_w_o,
    output logic [D_WIDTH-1:0] alu_result_w_o,
    output logic [D_WIDTH-1:0] read_data_w_o,
    output logic [4:0]         rd_w_o,
    output logic [D_WIDTH-1:0] pc_plus4_w_o,
    output logic               stall_m_o,
    output logic               misalign_o
);

    state_t             state_q;
    state_t             state_d;
    logic               is_load;
    logic               mem_op;
    logic               misaligned;
    logic               access;
    logic [D_WIDTH-1:0] load_data;

    assign is_load = (result_src_m_i == RS_LOAD);
    assign mem_op  = valid_m_i && (is_load || mem_write_m_i);
    assign access  = mem_op && !misaligned;

    // Alignment check on the effective address for the access size
    always_comb begin
        misaligned = 1'b0;
        if (mem_op) begin
            case (funct3_m_i[1:0])
                SZ_HALF: misaligned = alu_result_m_i[0];
                SZ_WORD: misaligned = (alu_result_m_i[1:0] != 2'b00);
                default: misaligned = 1'b0;
            endcase
        end
    end

    // FSM state register; reset aborts any outstanding access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: park in WAIT until the memory acknowledges
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access && !dmem_ack_i) state_d = WAIT;
            WAIT:    if (dmem_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: request in IDLE on a new access or throughout WAIT.
    // EX/MEM is frozen while stalled, so address/data stay driven from it.
    // Request is masked during reset so an in-flight access is dropped at once.
    always_comb begin
        dmem_req_o = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    dmem_req_o = access;
                WAIT:    dmem_req_o = 1'b1;
                default: dmem_req_o = 1'b0;
            endcase
        end
        stall_m_o = dmem_req_o && !dmem_ack_i;
        dmem_we_o = dmem_req_o && mem_write_m_i;
    end

    // Word address plus byte enables and lane-replicated store data
    always_comb begin
        dmem_addr_o = {alu_result_m_i[D_WIDTH-1:2], 2'b00};
        case (funct3_m_i[1:0])
            SZ_BYTE: begin
                dmem_be_o    = 4'b0001 << alu_result_m_i[1:0];
                dmem_wdata_o = {4{write_data_m_i[7:0]}};
            end
            SZ_HALF: begin
                dmem_be_o    = 4'b0011 << alu_result_m_i[1:0];
                dmem_wdata_o = {2{write_data_m_i[15:0]}};
            end
            default: begin
                dmem_be_o    = 4'b1111;
                dmem_wdata_o = write_data_m_i;
            end
        endcase
    end

    load_align u_load_align (
        .rdata  (dmem_rdata_i),
        .lane   (alu_result_m_i[1:0]),
        .funct3 (funct3_m_i),
        .data   (load_data)
    );

    // MEM/WB register: bubble on stall, empty slot or misaligned access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_w_o  <= 1'b0;
            result_src_w_o <= RS_ALU;
            alu_result_w_o <= '0;
            read_data_w_o  <= '0;
            rd_w_o         <= '0;
            pc_plus4_w_o   <= '0;
            misalign_o     <= 1'b0;
        end else begin
            misalign_o <= mem_op && misaligned;
            if (stall_m_o || !valid_m_i || misaligned) begin
                reg_write_w_o  <= 1'b0;
                result_src_w_o <= RS_ALU;
                alu_result_w_o <= '0;
                read_data_w_o  <= '0;
                rd_w_o         <= '0;
                pc_plus4_w_o   <= '0;
            end else begin
                reg_write_w_o  <= reg_write_m_i;
                result_src_w_o <= result_src_m_i;
                alu_result_w_o <= alu_result_m_i;
                read_data_w_o  <= is_load ? load_data : '0;
                rd_w_o         <= rd_m_i;
                pc_plus4_w_o   <= pc_plus4_m_i;
            end
        end
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter: D_WIDTH, 32, data/address width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 valid_m_i  in  1  EX/MEM slot holds a real instruction.
REQ-005 reg_write_m_i  in  1; result_src_m_i  in  2 (00 ALU, 01 load, 10 PC+4); mem_write_m_i  in  1; funct3_m_i  in  3  load/store size.
REQ-006 alu_result_m_i  in  32  effective address or ALU result; write_data_m_i  in  32  store data; rd_m_i  in  5; pc_plus4_m_i  in  32.
REQ-007 dmem_req_o  out  1; dmem_we_o  out  1; dmem_addr_o  out  32, word-aligned; dmem_be_o  out  4; dmem_wdata_o  out  32.
REQ-008 dmem_ack_i  in  1  completes request this cycle; dmem_rdata_i  in  32  word, valid with ack.
REQ-009 reg_write_w_o  out  1; result_src_w_o  out  2; alu_result_w_o  out  32; read_data_w_o  out  32; rd_w_o  out  5; pc_plus4_w_o  out  32: MEM/WB register feeding writeback.
REQ-010 stall_m_o  out  1  hold IF..EX/MEM; misalign_o  out  1  one-cycle error pulse.

Function
REQ-011 Access = valid_m_i and (result_src_m_i==01 or mem_write_m_i) and not misaligned.
REQ-012 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; no dmem request, misalign_o pulses next cycle, MEM/WB loads bubble (reg_write_w_o=0).
REQ-013 FSM states IDLE, WAIT.
REQ-014 IDLE + access: dmem_req_o high combinationally same cycle; ack same cycle -> complete, no stall; else stall_m_o=1, go WAIT.
REQ-015 WAIT: dmem_req_o, we, addr, be, wdata held from stalled EX/MEM inputs; stall_m_o=1 until the ack cycle; ack -> stall_m_o=0 that cycle, go IDLE.
REQ-016 Store byte enables: SB be=0001<<addr[1:0], wdata=byte replicated x4; SH be=0011<<addr[1:0], halfword replicated x2; SW be=1111.
REQ-017 Load extraction on ack: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word, lane chosen by addr[1:0].
REQ-018 MEM/WB register updates every cycle stall_m_o=0: loads EX/MEM fields, read_data_w_o = extracted load (0 for non-loads).
REQ-019 Cycle with stall_m_o=1: MEM/WB loads bubble (reg_write_w_o=0, rd_w_o=0), no duplicate writeback.
REQ-020 valid_m_i=0: no request, MEM/WB bubble.
REQ-021 Non-memory instruction: latency 1 cycle, no stall.
REQ-022 Load latency: ack-cycle + 1 to appear on read_data_w_o.
REQ-023 rd_m_i=0 with reg_write_m_i=1 passes through unchanged; x0 suppression is the register file's job.

Reset
REQ-024 rst asserted: FSM to IDLE immediately; all MEM/WB outputs, stall_m_o, misalign_o, dmem_req_o to 0.
REQ-025 rst mid-WAIT: request dropped, no writeback of the aborted access; an ack arriving during reset is ignored.

Structure
REQ-026 Shared package holds result_src encodings, funct3 load/store encodings, and state enum {IDLE, WAIT}.
REQ-027 One sub-module load_align: combinational lane select + sign/zero extension.

Verification
REQ-028 SW addr 0x100, data 0xDEADBEEF, ack same cycle -> dmem_be_o=1111, addr 0x100, no stall, bubble in MEM/WB.
REQ-029 LB addr 0x103, rdata 0x80FF_FF7F, ack after 3 cycles -> stall_m_o high 3 cycles, then read_data_w_o=0xFFFFFF80, reg_write_w_o=1 once.
REQ-030 LHU addr 0x102, rdata 0xBEEF1234 -> read_data_w_o=0x0000BEEF; SH addr 0x102 data 0x1234 -> be=1100, wdata=0x12341234.
REQ-031 LW addr 0x101 -> no dmem_req_o, misalign_o pulse, reg_write_w_o=0.
REQ-032 rst asserted during WAIT, ack one cycle later -> outputs 0, FSM IDLE, no writeback.
REQ-033 ALU op rd=5 result 0x42 -> next cycle alu_result_w_o=0x42, rd_w_o=5, result_src_w_o=00, no stall.
